// File: rtl/core_sram_bridge.sv
// Bridge from the core's fixed-latency inst/data SRAM ports to sram-like req/addr_ok/data_ok buses.
// One independent channel FSM per port; read data is held in a buffer until the next read returns.

module core_sram_bridge_ch #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [3:0]        i_wen,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_stall,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic              o_req,
  output logic              o_wr,
  output logic [1:0]        o_size,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  input  logic              i_addr_ok,
  input  logic              i_data_ok,
  input  logic [DATA_W-1:0] i_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              w_req;
  logic              w_busy;
  logic              w_issue;
  logic              w_use_latched;
  logic              w_capture;
  logic [1:0]        w_core_size;

  logic              r_wr;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_buf;

  // Transfer size from byte enables; reads and unexpected patterns are full words.
  function automatic logic [1:0] f_size(input logic [3:0] wen);
    logic [1:0] v;
    case (wen)
      4'b1111:                            v = 2'd2;
      4'b0011, 4'b1100:                   v = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: v = 2'd0;
      default:                            v = 2'd2;
    endcase
    return v;
  endfunction

  assign w_core_size = f_size(i_wen);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_req         = 1'b0;
    w_busy        = 1'b0;
    w_issue       = 1'b0;
    w_use_latched = 1'b0;
    w_capture     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_en) begin
          w_req   = 1'b1;
          w_busy  = 1'b1;
          w_issue = 1'b1;
          w_next  = i_addr_ok ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        w_req         = 1'b1;
        w_busy        = 1'b1;
        w_use_latched = 1'b1;
        if (i_addr_ok) w_next = S_RESP;
      end
      S_RESP: begin
        w_busy = 1'b1;
        if (i_data_ok) begin
          w_capture = ~r_wr;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        // Core en stays high while held; leaving only on pipeline release avoids a reissue.
        if (!i_stall) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields captured at issue so they stay stable while waiting for addr_ok.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_issue) begin
      r_wr    <= |i_wen;
      r_size  <= w_core_size;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)           r_buf <= '0;
    else if (w_capture) r_buf <= i_rdata;
  end

  // Bus fields are zero unless a request is being presented; reset forces them quiet.
  always_comb begin
    o_req   = 1'b0;
    o_wr    = 1'b0;
    o_size  = 2'd0;
    o_addr  = '0;
    o_wdata = '0;
    if (rst && w_issue) begin
      o_req   = 1'b1;
      o_wr    = |i_wen;
      o_size  = w_core_size;
      o_addr  = i_addr;
      o_wdata = i_wdata;
    end else if (rst && w_use_latched) begin
      o_req   = 1'b1;
      o_wr    = r_wr;
      o_size  = r_size;
      o_addr  = r_addr;
      o_wdata = r_wdata;
    end
  end

  assign o_busy  = rst & w_busy;
  assign o_rdata = r_buf;

endmodule

module core_sram_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_sram_en,
  input  logic [3:0]        inst_sram_wen,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic [DATA_W-1:0] inst_sram_rdata,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  input  logic              stall_in,
  output logic              stallreq,
  output logic              inst_req,
  output logic              inst_wr,
  output logic [1:0]        inst_size,
  output logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_wdata,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  logic w_inst_busy;
  logic w_data_busy;

  core_sram_bridge_ch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_inst_ch (
    .clk       (clk),
    .rst       (rst),
    .i_en      (inst_sram_en),
    .i_wen     (inst_sram_wen),
    .i_addr    (inst_sram_addr),
    .i_wdata   (inst_sram_wdata),
    .i_stall   (stall_in),
    .o_rdata   (inst_sram_rdata),
    .o_busy    (w_inst_busy),
    .o_req     (inst_req),
    .o_wr      (inst_wr),
    .o_size    (inst_size),
    .o_addr    (inst_addr),
    .o_wdata   (inst_wdata),
    .i_addr_ok (inst_addr_ok),
    .i_data_ok (inst_data_ok),
    .i_rdata   (inst_rdata)
  );

  core_sram_bridge_ch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_data_ch (
    .clk       (clk),
    .rst       (rst),
    .i_en      (data_sram_en),
    .i_wen     (data_sram_wen),
    .i_addr    (data_sram_addr),
    .i_wdata   (data_sram_wdata),
    .i_stall   (stall_in),
    .o_rdata   (data_sram_rdata),
    .o_busy    (w_data_busy),
    .o_req     (data_req),
    .o_wr      (data_wr),
    .o_size    (data_size),
    .o_addr    (data_addr),
    .o_wdata   (data_wdata),
    .i_addr_ok (data_addr_ok),
    .i_data_ok (data_data_ok),
    .i_rdata   (data_rdata)
  );

  // A channel parked in DONE does not release the pipeline while the other is still busy.
  assign stallreq = w_inst_busy | w_data_busy;

endmodule

// File: tb/tb_core_sram_bridge.sv
// Directed bench for core_sram_bridge: inputs driven 1ns after each rising edge,
// combinational and buffered outputs checked 1ns later.

module tb_core_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stall_in;
  logic        stallreq;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_checks = 0;
  int n_errors = 0;

  core_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stall_in        (stall_in),
    .stallreq        (stallreq),
    .inst_req        (inst_req),
    .inst_wr         (inst_wr),
    .inst_size       (inst_size),
    .inst_addr       (inst_addr),
    .inst_wdata      (inst_wdata),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata      (inst_rdata),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge, where the next cycle's inputs are applied.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    inst_sram_en = 1'b0; inst_sram_wen = 4'd0; inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
    data_sram_en = 1'b0; data_sram_wen = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
    stall_in = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    cyc(); cyc();
    settle();
    chk("rst_stallreq", 32'(stallreq), 32'd0);
    chk("rst_inst_req", 32'(inst_req), 32'd0);
    chk("rst_data_addr", data_addr, 32'd0);
    chk("rst_inst_rdata", inst_sram_rdata, 32'd0);
    rst = 1'b1;

    // Instruction word read: addr_ok same cycle, data_ok next cycle
    cyc();
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0000; inst_addr_ok = 1'b1; stall_in = 1'b1;
    settle();
    chk("t1_c0_req", 32'(inst_req), 32'd1);
    chk("t1_c0_size", 32'(inst_size), 32'd2);
    chk("t1_c0_wr", 32'(inst_wr), 32'd0);
    chk("t1_c0_addr", inst_addr, 32'hBFC0_0000);
    chk("t1_c0_stallreq", 32'(stallreq), 32'd1);
    cyc();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2402_0001;
    settle();
    chk("t1_c1_req", 32'(inst_req), 32'd0);
    chk("t1_c1_stallreq", 32'(stallreq), 32'd1);
    cyc();
    inst_data_ok = 1'b0; inst_rdata = 32'd0; stall_in = 1'b0;
    settle();
    chk("t1_c2_stallreq", 32'(stallreq), 32'd0);
    chk("t1_c2_req", 32'(inst_req), 32'd0);
    chk("t1_c2_rdata", inst_sram_rdata, 32'h2402_0001);
    cyc();
    inst_sram_en = 1'b0; inst_sram_addr = 32'd0;
    settle();
    chk("t1_c3_req", 32'(inst_req), 32'd0);
    chk("t1_c3_addr", inst_addr, 32'd0);
    chk("t1_c3_rdata", inst_sram_rdata, 32'h2402_0001);

    // Data byte store, addr_ok delayed 3 cycles; core inputs disturbed while in REQ
    cyc();
    data_sram_en = 1'b1; data_sram_wen = 4'b0100; data_sram_addr = 32'h8000_0002;
    data_sram_wdata = 32'h00AB_0000; stall_in = 1'b1;
    settle();
    chk("t2_c0_req", 32'(data_req), 32'd1);
    chk("t2_c0_wr", 32'(data_wr), 32'd1);
    chk("t2_c0_size", 32'(data_size), 32'd0);
    chk("t2_c0_stallreq", 32'(stallreq), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      data_sram_addr = 32'h1234_5678; data_sram_wdata = 32'hFFFF_FFFF; data_sram_wen = 4'b1111;
      if (i == 3) data_addr_ok = 1'b1;
      settle();
      chk("t2_req_held", 32'(data_req), 32'd1);
      chk("t2_addr_stable", data_addr, 32'h8000_0002);
      chk("t2_wdata_stable", data_wdata, 32'h00AB_0000);
      chk("t2_size_stable", 32'(data_size), 32'd0);
    end
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_BABE;
    settle();
    chk("t2_resp_req", 32'(data_req), 32'd0);
    chk("t2_resp_stallreq", 32'(stallreq), 32'd1);
    cyc();
    data_data_ok = 1'b0; data_rdata = 32'd0; stall_in = 1'b0;
    settle();
    chk("t2_done_stallreq", 32'(stallreq), 32'd0);
    chk("t2_done_buf", data_sram_rdata, 32'd0);
    cyc();
    data_sram_en = 1'b0; data_sram_wen = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;

    // Concurrent: inst done at cycle 2, data done at cycle 6
    cyc();
    inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_0100; inst_addr_ok = 1'b1;
    data_sram_en = 1'b1; data_sram_addr = 32'h0000_0200; stall_in = 1'b1;
    settle();
    chk("t3_c0_inst_req", 32'(inst_req), 32'd1);
    chk("t3_c0_data_req", 32'(data_req), 32'd1);
    cyc();
    inst_addr_ok = 1'b0;
    cyc();
    inst_data_ok = 1'b1; inst_rdata = 32'h1111_1111;
    cyc();
    inst_data_ok = 1'b0; inst_rdata = 32'd0; data_addr_ok = 1'b1;
    settle();
    chk("t3_c3_data_req", 32'(data_req), 32'd1);
    chk("t3_c3_inst_req", 32'(inst_req), 32'd0);
    cyc();
    data_addr_ok = 1'b0;
    settle();
    chk("t3_c4_inst_noreissue", 32'(inst_req), 32'd0);
    chk("t3_c4_stallreq", 32'(stallreq), 32'd1);
    chk("t3_c4_inst_rdata", inst_sram_rdata, 32'h1111_1111);
    cyc();
    inst_data_ok = 1'b1; inst_rdata = 32'hBAD0_BAD0;
    settle();
    chk("t3_c5_inst_noreissue", 32'(inst_req), 32'd0);
    cyc();
    inst_data_ok = 1'b0; inst_rdata = 32'd0;
    data_data_ok = 1'b1; data_rdata = 32'h2222_2222;
    settle();
    chk("t3_c6_stallreq", 32'(stallreq), 32'd1);
    cyc();
    data_data_ok = 1'b0; data_rdata = 32'd0; stall_in = 1'b0;
    settle();
    chk("t3_c7_stallreq", 32'(stallreq), 32'd0);
    chk("t3_c7_inst_rdata", inst_sram_rdata, 32'h1111_1111);
    chk("t3_c7_data_rdata", data_sram_rdata, 32'h2222_2222);

    // Back-to-back: next fetch issued in the cycle after DONE exit
    cyc();
    inst_sram_addr = 32'h0000_0104; data_sram_en = 1'b0; data_sram_addr = 32'd0; stall_in = 1'b1;
    settle();
    chk("t4_c0_req", 32'(inst_req), 32'd1);
    chk("t4_c0_addr", inst_addr, 32'h0000_0104);
    chk("t4_c0_rdata_prev", inst_sram_rdata, 32'h1111_1111);
    cyc();
    inst_addr_ok = 1'b1;
    settle();
    chk("t4_c1_req", 32'(inst_req), 32'd1);
    cyc();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3333_3333;
    settle();
    chk("t4_c2_rdata_prev", inst_sram_rdata, 32'h1111_1111);
    cyc();
    inst_data_ok = 1'b0; inst_rdata = 32'd0; stall_in = 1'b0;
    settle();
    chk("t4_c3_rdata_new", inst_sram_rdata, 32'h3333_3333);
    cyc();
    inst_sram_en = 1'b0; inst_sram_addr = 32'd0;

    // Reset while in RESP, then a late response
    cyc();
    inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_0300; inst_addr_ok = 1'b1; stall_in = 1'b1;
    cyc();
    inst_addr_ok = 1'b0; rst = 1'b0; inst_sram_en = 1'b0; inst_sram_addr = 32'd0; stall_in = 1'b0;
    cyc();
    rst = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    settle();
    chk("t5_c0_stallreq", 32'(stallreq), 32'd0);
    chk("t5_c0_req", 32'(inst_req), 32'd0);
    chk("t5_c0_rdata", inst_sram_rdata, 32'd0);
    cyc();
    inst_data_ok = 1'b0; inst_rdata = 32'd0;
    settle();
    chk("t5_c1_rdata", inst_sram_rdata, 32'd0);
    chk("t5_c1_stallreq", 32'(stallreq), 32'd0);

    // Half-word store then word read on the data channel
    cyc();
    data_sram_en = 1'b1; data_sram_wen = 4'b1100; data_sram_addr = 32'h0000_0400;
    data_sram_wdata = 32'h1234_0000; data_addr_ok = 1'b1; stall_in = 1'b1;
    settle();
    chk("t6_half_size", 32'(data_size), 32'd1);
    chk("t6_half_wr", 32'(data_wr), 32'd1);
    chk("t6_half_wdata", data_wdata, 32'h1234_0000);
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h9999_9999;
    cyc();
    data_data_ok = 1'b0; data_rdata = 32'd0; stall_in = 1'b0;
    settle();
    chk("t6_half_buf", data_sram_rdata, 32'd0);
    cyc();
    data_sram_wen = 4'd0; data_sram_addr = 32'h0000_0404; data_sram_wdata = 32'd0;
    data_addr_ok = 1'b1; stall_in = 1'b1;
    settle();
    chk("t6_rd_size", 32'(data_size), 32'd2);
    chk("t6_rd_wr", 32'(data_wr), 32'd0);
    chk("t6_rd_addr", data_addr, 32'h0000_0404);
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5566_7788;
    cyc();
    data_data_ok = 1'b0; data_rdata = 32'd0; stall_in = 1'b0; data_sram_en = 1'b0;
    data_sram_addr = 32'd0;
    settle();
    chk("t6_rd_buf", data_sram_rdata, 32'h5566_7788);
    chk("t6_stallreq", 32'(stallreq), 32'd0);
    cyc();
    settle();
    chk("t6_idle_req", 32'(data_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
